mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
//------------------------------------------------------------------------------
// mem_access_stage : pipeline MEM stage with a req/gnt/rvalid data-memory port
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  LSType_i,
  input  logic [4:0]  WB_control_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] StoreData_i,
  input  logic [4:0]  RegDst_i,
  input  logic [31:0] PC_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  WB_control,
  output logic [31:0] MemData,
  output logic [31:0] ALUResult,
  output logic [4:0]  RegDst,
  output logic [31:0] PC,
  output logic        misaligned
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_lstype;

  logic        w_mem_op, w_is_byte, w_is_half, w_is_word, w_mis, w_go;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_capture, w_load_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  assign w_mem_op  = valid_i & (MemRead_i | MemWrite_i);
  assign w_is_byte = (LSType_i == 3'b000) | (LSType_i == 3'b100);
  assign w_is_half = (LSType_i == 3'b001) | (LSType_i == 3'b101);
  assign w_is_word = ~w_is_byte & ~w_is_half;
  assign w_mis     = w_mem_op & ((w_is_half & ALUResult_i[0]) |
                                 (w_is_word & (ALUResult_i[1:0] != 2'b00)));
  assign w_go      = w_mem_op & ~w_mis;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = StoreData_i;
    if (w_is_byte) begin
      w_be    = 4'b0001 << ALUResult_i[1:0];
      w_wdata = {4{StoreData_i[7:0]}};
    end else if (w_is_half) begin
      w_be    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{StoreData_i[15:0]}};
    end
  end

  // IDLE drives the port straight from the inputs; REQ/WAIT replay the captured copy
  always_comb begin
    w_next      = r_state;
    dmem_req    = 1'b0;
    dmem_we     = MemWrite_i;
    dmem_addr   = {ALUResult_i[31:2], 2'b00};
    dmem_be     = w_be;
    dmem_wdata  = w_wdata;
    stall       = 1'b0;
    w_capture   = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          dmem_req  = 1'b1;
          w_capture = 1'b1;
          if (dmem_gnt) begin
            if (!MemWrite_i) begin
              w_next = S_WAIT;
              stall  = 1'b1;
            end
          end else begin
            w_next = S_REQ;
            stall  = 1'b1;
          end
        end
      end
      S_REQ: begin
        dmem_req   = 1'b1;
        dmem_we    = r_we;
        dmem_addr  = {r_addr[31:2], 2'b00};
        dmem_be    = r_be;
        dmem_wdata = r_wdata;
        stall      = 1'b1;
        if (dmem_gnt) begin
          if (r_we) begin
            w_next = S_IDLE;
            stall  = 1'b0;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dmem_we    = r_we;
        dmem_addr  = {r_addr[31:2], 2'b00};
        dmem_be    = r_be;
        dmem_wdata = r_wdata;
        if (dmem_rvalid) begin
          w_next      = S_IDLE;
          w_load_done = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (RESET) begin
      dmem_req    = 1'b0;
      stall       = 1'b0;
      w_capture   = 1'b0;
      w_load_done = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'd0;
      r_we     <= 1'b0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_lstype <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_addr   <= ALUResult_i;
        r_we     <= MemWrite_i;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_lstype <= LSType_i;
      end
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_lstype)
      3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_fmt = {24'd0, w_byte};
      3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_fmt = {16'd0, w_half};
      default: w_load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wb_valid   <= 1'b0;
      WB_control <= 5'd0;
      MemData    <= 32'd0;
      ALUResult  <= 32'd0;
      RegDst     <= 5'd0;
      PC         <= 32'd0;
      misaligned <= 1'b0;
    end else if (stall) begin
      wb_valid   <= 1'b0;
      WB_control <= 5'd0;
      MemData    <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      wb_valid   <= valid_i;
      WB_control <= w_mis ? 5'd0 : WB_control_i;
      MemData    <= w_load_done ? w_load_fmt : 32'd0;
      ALUResult  <= ALUResult_i;
      RegDst     <= RegDst_i;
      PC         <= PC_i;
      misaligned <= w_mis;
    end
  end

endmodule

`default_nettype wire
